// File: rtl/gray_counter_arbiter.sv
// Round-robin arbiter multiplexing NREQ one-entry operation slots onto a shared
// GrayCounter; issues one saturating inc/dec/load/read every three cycles.
module gray_counter_arbiter #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req_ena,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [WIDTH*NREQ-1:0]   req_v,
  output logic [NREQ-1:0]         req_rdy,
  output logic [NREQ-1:0]         done,
  output logic                    done_sat,
  output logic [WIDTH-1:0]        done_value,
  output logic                    ctr_increment_ena,
  output logic                    ctr_decrement_ena,
  output logic                    ctr_writeBin_ena,
  output logic [WIDTH-1:0]        ctr_writeBin_v,
  input  logic                    ctr_increment_rdy,
  input  logic                    ctr_decrement_rdy,
  input  logic                    ctr_writeBin_rdy,
  input  logic [WIDTH-1:0]        ctr_readBin
);

  localparam int unsigned      PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  typedef enum logic [1:0] {OP_INC = 2'b00, OP_DEC = 2'b01, OP_LOAD = 2'b10, OP_READ = 2'b11} op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE} state_e;
  typedef enum logic [1:0] {ACT_NONE, ACT_INC, ACT_DEC, ACT_WR} act_e;

  state_e             state, state_nx;
  act_e               act, act_nx;
  logic [PW-1:0]      rr_ptr, rr_nx;
  logic [PW-1:0]      gnt, gnt_nx;
  logic               sat, sat_nx;
  logic [WIDTH-1:0]   wr_v, wr_v_nx;
  logic [WIDTH-1:0]   last_value;
  logic               rdy_en;

  logic [NREQ-1:0]    slot_valid;
  op_e                slot_op [NREQ];
  logic [WIDTH-1:0]   slot_v  [NREQ];

  logic [NREQ-1:0]    elig;
  logic               found;
  logic [PW-1:0]      cand;

  // A slot is eligible only when the counter port its op needs is ready.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      case (slot_op[i])
        OP_INC:  elig[i] = slot_valid[i] & ctr_increment_rdy;
        OP_DEC:  elig[i] = slot_valid[i] & ctr_decrement_rdy;
        OP_LOAD: elig[i] = slot_valid[i] & ctr_writeBin_rdy;
        default: elig[i] = slot_valid[i];
      endcase
    end
  end

  always_comb begin
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = k + 32'(rr_ptr);
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && elig[idx[PW-1:0]]) begin
        found = 1'b1;
        cand  = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_nx = state;
    rr_nx    = rr_ptr;
    gnt_nx   = gnt;
    act_nx   = act;
    sat_nx   = sat;
    wr_v_nx  = wr_v;
    case (state)
      ST_IDLE: begin
        if (found) begin
          gnt_nx   = cand;
          rr_nx    = (cand == PW'(NREQ - 1)) ? '0 : cand + PW'(1);
          state_nx = ST_ISSUE;
          act_nx   = ACT_NONE;
          sat_nx   = 1'b0;
          // Saturation is judged against the counter value seen at grant time.
          case (slot_op[cand])
            OP_INC: begin
              if (ctr_readBin >= MAX_W) sat_nx = 1'b1;
              else                      act_nx = ACT_INC;
            end
            OP_DEC: begin
              if (ctr_readBin == '0) sat_nx = 1'b1;
              else                   act_nx = ACT_DEC;
            end
            OP_LOAD: begin
              act_nx = ACT_WR;
              if (slot_v[cand] > MAX_W) begin
                wr_v_nx = MAX_W;
                sat_nx  = 1'b1;
              end else begin
                wr_v_nx = slot_v[cand];
              end
            end
            default: ;
          endcase
        end
      end
      ST_ISSUE:  state_nx = ST_SETTLE;
      ST_SETTLE: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      gnt        <= '0;
      act        <= ACT_NONE;
      sat        <= 1'b0;
      wr_v       <= '0;
      last_value <= '0;
      rdy_en     <= 1'b0;
      slot_valid <= '0;
    end else begin
      state  <= state_nx;
      rr_ptr <= rr_nx;
      gnt    <= gnt_nx;
      act    <= act_nx;
      sat    <= sat_nx;
      wr_v   <= wr_v_nx;
      rdy_en <= 1'b1;
      if (state == ST_SETTLE) last_value <= ctr_readBin;
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (state == ST_SETTLE && gnt == PW'(i)) begin
          slot_valid[i] <= 1'b0;
        end else if (req_ena[i] && req_rdy[i]) begin
          slot_valid[i] <= 1'b1;
          slot_op[i]    <= op_e'(req_op[2*i +: 2]);
          slot_v[i]     <= req_v[WIDTH*i +: WIDTH];
        end
      end
    end
  end

  // rdy_en keeps req_rdy low while reset is held, even though the slots are already empty.
  assign req_rdy = rdy_en ? ~slot_valid : '0;

  always_comb begin
    done = '0;
    if (state == ST_SETTLE) done[gnt] = 1'b1;
  end

  assign done_sat          = (state == ST_SETTLE) && sat;
  assign done_value        = (state == ST_SETTLE) ? ctr_readBin : last_value;
  assign ctr_increment_ena = (state == ST_ISSUE) && (act == ACT_INC);
  assign ctr_decrement_ena = (state == ST_ISSUE) && (act == ACT_DEC);
  assign ctr_writeBin_ena  = (state == ST_ISSUE) && (act == ACT_WR);
  assign ctr_writeBin_v    = wr_v;

endmodule

// File: tb/tb_gray_counter_arbiter.sv
// Self-checking bench for gray_counter_arbiter: behavioural counters, a done-event
// scoreboard, and per-scenario tasks.
module tb_gray_counter_arbiter;
  localparam int unsigned W = 10;
  localparam int unsigned N = 4;
  localparam logic [1:0] OP_INC = 2'b00, OP_DEC = 2'b01, OP_LOAD = 2'b10, OP_READ = 2'b11;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  logic [N-1:0]   req_ena = '0;
  logic [2*N-1:0] req_op = '0;
  logic [W*N-1:0] req_v = '0;
  logic [N-1:0]   req_rdy, done;
  logic           done_sat, inc_ena, dec_ena, wr_ena;
  logic [W-1:0]   done_value, wr_v;
  logic           inc_rdy = 1'b1, dec_rdy = 1'b1, wr_rdy = 1'b1;
  logic [W-1:0]   cnt = '0;

  logic [N-1:0]   r2_ena = '0;
  logic [2*N-1:0] r2_op = '0;
  logic [W*N-1:0] r2_v = '0;
  logic [N-1:0]   r2_rdy, r2_done;
  logic           r2_sat, r2_inc, r2_dec, r2_wr;
  logic [W-1:0]   r2_value, r2_wr_v;
  logic [W-1:0]   cnt2 = '0;

  logic           preset_req = 1'b0;
  logic [W-1:0]   preset_val = '0;

  gray_counter_arbiter #(.WIDTH(W), .NREQ(N)) u_dut (
    .CLK(CLK), .nRST(nRST), .req_ena(req_ena), .req_op(req_op), .req_v(req_v),
    .req_rdy(req_rdy), .done(done), .done_sat(done_sat), .done_value(done_value),
    .ctr_increment_ena(inc_ena), .ctr_decrement_ena(dec_ena), .ctr_writeBin_ena(wr_ena),
    .ctr_writeBin_v(wr_v), .ctr_increment_rdy(inc_rdy), .ctr_decrement_rdy(dec_rdy),
    .ctr_writeBin_rdy(wr_rdy), .ctr_readBin(cnt));

  gray_counter_arbiter #(.WIDTH(W), .NREQ(N), .MAX_VAL(600)) u_dut600 (
    .CLK(CLK), .nRST(nRST), .req_ena(r2_ena), .req_op(r2_op), .req_v(r2_v),
    .req_rdy(r2_rdy), .done(r2_done), .done_sat(r2_sat), .done_value(r2_value),
    .ctr_increment_ena(r2_inc), .ctr_decrement_ena(r2_dec), .ctr_writeBin_ena(r2_wr),
    .ctr_writeBin_v(r2_wr_v), .ctr_increment_rdy(1'b1), .ctr_decrement_rdy(1'b1),
    .ctr_writeBin_rdy(1'b1), .ctr_readBin(cnt2));

  always @(posedge CLK) begin
    if (preset_req)   cnt <= preset_val;
    else if (inc_ena) cnt <= cnt + 1'b1;
    else if (dec_ena) cnt <= cnt - 1'b1;
    else if (wr_ena)  cnt <= wr_v;
    if (preset_req)   cnt2 <= preset_val;
    else if (r2_inc)  cnt2 <= cnt2 + 1'b1;
    else if (r2_dec)  cnt2 <= cnt2 - 1'b1;
    else if (r2_wr)   cnt2 <= r2_wr_v;
  end

  typedef struct packed {
    logic [N-1:0] d;
    logic         sat;
    logic [W-1:0] val;
    int unsigned  cyc;
  } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  int unsigned obs_rd = 0;
  int unsigned cyc = 0;
  int unsigned inc_n = 0, dec_n = 0, wr_n = 0, multi_n = 0;
  int          tests = 0, fails = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (done != '0) obs_q.push_back('{d: done, sat: done_sat, val: done_value, cyc: cyc});
    if (inc_ena) inc_n++;
    if (dec_ena) dec_n++;
    if (wr_ena)  wr_n++;
    if ((int'(inc_ena) + int'(dec_ena) + int'(wr_ena)) > 1) multi_n++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic enq(input int unsigned i, input logic [1:0] op, input logic [W-1:0] v);
    req_ena[i]       = 1'b1;
    req_op[2*i +: 2] = op;
    req_v[W*i +: W]  = v;
  endtask

  task automatic push_exp(input int unsigned i, input logic s, input logic [W-1:0] v);
    ev_t e;
    e = '{d: '0, sat: s, val: v, cyc: 0};
    e.d[i] = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic wait_obs(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (obs_q.size() >= obs_rd + exp_q.size()) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    #1;
    if (obs_q.size() >= obs_rd + exp_q.size()) ok = 1'b1;
  endtask

  task automatic set_counter(input logic [W-1:0] v);
    @(negedge CLK);
    preset_val = v;
    preset_req = 1'b1;
    @(negedge CLK);
    preset_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    preset_val = '0;
    preset_req = 1'b1;
    repeat (2) @(negedge CLK);
    tests++;
    if (req_rdy !== '0) begin fails++; $display("FAIL reset_rdy: got %b want 0000", req_rdy); end
    tests++;
    if (done !== '0 || done_sat !== 1'b0 || done_value !== '0) begin
      fails++; $display("FAIL reset_done: got done=%b sat=%b val=%0d want 0 0 0", done, done_sat, done_value);
    end
    tests++;
    if ({inc_ena, dec_ena, wr_ena} !== 3'b000) begin
      fails++; $display("FAIL reset_ena: got %b want 000", {inc_ena, dec_ena, wr_ena});
    end
    nRST = 1'b1;
    preset_req = 1'b0;
    @(negedge CLK);
    tests++;
    if (req_rdy !== 4'b1111) begin fails++; $display("FAIL reset_release_rdy: got %b want 1111", req_rdy); end
  endtask

  task automatic test_single_inc();
    int unsigned base;
    bit ok;
    ev_t e, o;
    set_counter(10'd5);
    base = inc_n;
    enq(0, OP_INC, '0);
    push_exp(0, 1'b0, 10'd6);
    @(negedge CLK);
    req_ena = '0;
    tests++;
    if (req_rdy[0] !== 1'b0 || inc_ena !== 1'b0) begin
      fails++; $display("FAIL single_t1: got rdy0=%b inc=%b want 0 0", req_rdy[0], inc_ena);
    end
    @(negedge CLK);
    tests++;
    if (inc_ena !== 1'b1) begin fails++; $display("FAIL single_t2_inc: got %b want 1", inc_ena); end
    @(negedge CLK);
    tests++;
    if (done !== 4'b0001 || done_value !== 10'd6 || done_sat !== 1'b0) begin
      fails++; $display("FAIL single_t3_done: got done=%b val=%0d sat=%b want 0001 6 0", done, done_value, done_sat);
    end
    enq(0, OP_INC, '0);
    @(negedge CLK);
    req_ena = '0;
    tests++;
    if (req_rdy[0] !== 1'b1) begin fails++; $display("FAIL single_t4_rdy: got %b want 1", req_rdy[0]); end
    tests++;
    if (inc_n - base !== 1) begin fails++; $display("FAIL single_inc_count: got %0d want 1", inc_n - base); end
    wait_obs(10, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL single_timeout: got no done event want one"); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      tests++;
      if (o.d !== e.d || o.sat !== e.sat || o.val !== e.val) begin
        fails++; $display("FAIL single_sb: got done=%b sat=%b val=%0d want done=%b sat=%b val=%0d",
                          o.d, o.sat, o.val, e.d, e.sat, e.val);
      end
    end
    exp_q.delete();
    repeat (6) @(negedge CLK);
    #1;
    tests++;
    if (inc_n - base !== 1 || obs_q.size() != obs_rd) begin
      fails++; $display("FAIL single_reject_reenq: got incs=%0d extra_done=%0d want 1 0",
                        inc_n - base, obs_q.size() - obs_rd);
    end
  endtask

  task automatic test_all_inc();
    bit ok;
    ev_t e, o;
    int unsigned prev_cyc;
    bit have_prev;
    do_reset();
    set_counter(10'd100);
    for (int unsigned i = 0; i < N; i++) begin
      enq(i, OP_INC, '0);
      push_exp(i, 1'b0, W'(101 + i));
    end
    @(negedge CLK);
    req_ena = '0;
    wait_obs(30, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL all_inc_timeout: got %0d events want 4", obs_q.size() - obs_rd); end
    have_prev = 1'b0;
    prev_cyc = 0;
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      tests++;
      if (o.d !== e.d || o.sat !== e.sat || o.val !== e.val) begin
        fails++; $display("FAIL all_inc_sb: got done=%b sat=%b val=%0d want done=%b sat=%b val=%0d",
                          o.d, o.sat, o.val, e.d, e.sat, e.val);
      end
      if (have_prev) begin
        tests++;
        if (o.cyc - prev_cyc !== 3) begin
          fails++; $display("FAIL all_inc_spacing: got %0d cycles want 3", o.cyc - prev_cyc);
        end
      end
      prev_cyc = o.cyc;
      have_prev = 1'b1;
    end
    exp_q.delete();
    @(negedge CLK);
    tests++;
    if (cnt !== 10'd104) begin fails++; $display("FAIL all_inc_final: got %0d want 104", cnt); end
  endtask

  task automatic test_saturation();
    int unsigned base;
    bit ok;
    ev_t e, o;
    set_counter(10'd0);
    base = dec_n;
    enq(2, OP_DEC, '0);
    push_exp(2, 1'b1, 10'd0);
    @(negedge CLK);
    req_ena = '0;
    wait_obs(12, ok);
    set_counter(10'd1023);
    base = base + (inc_n - inc_n);
    tests++;
    if (dec_n != base) begin fails++; $display("FAIL sat_dec_ena: got %0d decs want 0", dec_n - base); end
    base = inc_n;
    enq(1, OP_INC, '0);
    push_exp(1, 1'b1, 10'd1023);
    @(negedge CLK);
    req_ena = '0;
    wait_obs(12, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL sat_timeout: got %0d events want 2", obs_q.size() - obs_rd); end
    tests++;
    if (inc_n != base) begin fails++; $display("FAIL sat_inc_ena: got %0d incs want 0", inc_n - base); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      tests++;
      if (o.d !== e.d || o.sat !== e.sat || o.val !== e.val) begin
        fails++; $display("FAIL sat_sb: got done=%b sat=%b val=%0d want done=%b sat=%b val=%0d",
                          o.d, o.sat, o.val, e.d, e.sat, e.val);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_load_clamp();
    logic [W-1:0] vals [2];
    logic [W-1:0] want [2];
    logic         want_sat [2];
    int unsigned  nwr;
    logic [W-1:0] got_wv, got_val;
    logic [N-1:0] got_d;
    logic         got_sat;
    vals[0] = 10'd900; want[0] = 10'd600; want_sat[0] = 1'b1;
    vals[1] = 10'd17;  want[1] = 10'd17;  want_sat[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      r2_ena[3]      = 1'b1;
      r2_op[7:6]     = OP_LOAD;
      r2_v[3*W +: W] = vals[k];
      @(negedge CLK);
      r2_ena = '0;
      nwr = 0; got_wv = '0; got_d = '0; got_sat = 1'b0; got_val = '0;
      for (int c = 0; c < 10; c++) begin
        if (r2_wr) begin nwr++; got_wv = r2_wr_v; end
        if (r2_done != '0 && got_d == '0) begin got_d = r2_done; got_sat = r2_sat; got_val = r2_value; end
        @(negedge CLK);
      end
      tests++;
      if (nwr != 1 || got_wv !== want[k]) begin
        fails++; $display("FAIL load_wr_%0d: got writes=%0d v=%0d want 1 %0d", k, nwr, got_wv, want[k]);
      end
      tests++;
      if (got_d !== 4'b1000 || got_sat !== want_sat[k] || got_val !== want[k]) begin
        fails++; $display("FAIL load_done_%0d: got done=%b sat=%b val=%0d want 1000 %b %0d",
                          k, got_d, got_sat, got_val, want_sat[k], want[k]);
      end
    end
  endtask

  task automatic test_rdy_block();
    bit ok;
    ev_t e, o;
    do_reset();
    set_counter(10'd40);
    inc_rdy = 1'b0;
    enq(0, OP_INC, '0);
    enq(1, OP_READ, '0);
    push_exp(1, 1'b0, 10'd40);
    @(negedge CLK);
    req_ena = '0;
    wait_obs(12, ok);
    repeat (6) @(negedge CLK);
    #1;
    tests++;
    if (!ok || obs_q.size() != obs_rd + 1 || req_rdy[0] !== 1'b0) begin
      fails++; $display("FAIL rdy_block_pending: got events=%0d rdy0=%b want 1 0", obs_q.size() - obs_rd, req_rdy[0]);
    end
    inc_rdy = 1'b1;
    push_exp(0, 1'b0, 10'd41);
    wait_obs(12, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL rdy_block_timeout: got %0d events want 2", obs_q.size() - obs_rd); end
    while (exp_q.size() > 0 && obs_rd < obs_q.size()) begin
      e = exp_q.pop_front();
      o = obs_q[obs_rd];
      obs_rd++;
      tests++;
      if (o.d !== e.d || o.sat !== e.sat || o.val !== e.val) begin
        fails++; $display("FAIL rdy_block_sb: got done=%b sat=%b val=%0d want done=%b sat=%b val=%0d",
                          o.d, o.sat, o.val, e.d, e.sat, e.val);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_reset_abort();
    int unsigned e0, s0;
    do_reset();
    set_counter(10'd50);
    s0 = obs_q.size();
    enq(0, OP_INC, '0);
    @(negedge CLK);
    req_ena = '0;
    @(negedge CLK);
    tests++;
    if (inc_ena !== 1'b1) begin fails++; $display("FAIL abort_issue: got inc=%b want 1", inc_ena); end
    nRST = 1'b0;
    @(negedge CLK);
    #1;
    e0 = inc_n + dec_n + wr_n;
    tests++;
    if (done !== '0 || {inc_ena, dec_ena, wr_ena} !== 3'b000) begin
      fails++; $display("FAIL abort_after_rst: got done=%b ena=%b want 0000 000", done, {inc_ena, dec_ena, wr_ena});
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    tests++;
    if (req_rdy !== 4'b1111) begin fails++; $display("FAIL abort_rdy: got %b want 1111", req_rdy); end
    repeat (8) @(negedge CLK);
    #1;
    tests++;
    if (inc_n + dec_n + wr_n != e0 || obs_q.size() != s0) begin
      fails++; $display("FAIL abort_quiet: got enables=%0d dones=%0d want 0 0",
                        inc_n + dec_n + wr_n - e0, obs_q.size() - s0);
    end
    obs_rd = obs_q.size();
  endtask

  initial begin
    test_reset();
    test_single_inc();
    test_all_inc();
    test_saturation();
    test_load_clamp();
    test_rdy_block();
    test_reset_abort();
    tests++;
    if (multi_n != 0) begin fails++; $display("FAIL ena_exclusive: got %0d multi-enable cycles want 0", multi_n); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
